// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler for a shared 8:1 single-bit mux: arbitrates requests,
// drives the mux select with a bounded hold time, and registers the mux output.
module mux8_rr_scheduler #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       mux_o,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       data_o,
  output logic       data_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  state_t           next_state_s;
  logic [2:0]       ptr_r;
  logic [2:0]       winner_s;
  logic [CNT_W-1:0] cnt_r;
  logic             take_s;
  logic             leave_s;

  // First set request bit scanning upward from just past the last winner.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = p + 3'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // Next-state, grant-take and grant-release decisions.
  always_comb begin
    next_state_s = IDLE;
    take_s       = 1'b0;
    winner_s     = rr_pick(req, ptr_r);
    leave_s      = (state_r == GRANT) &&
                   (!req[sel] || !en ||
                    ((cnt_r == HOLD_LIM) && ((req & ~gnt) != 8'h00)));
    case (state_r)
      IDLE, GAP: begin
        if (en && (req != 8'h00)) begin
          next_state_s = GRANT;
          take_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      GRANT: begin
        if (leave_s) begin
          next_state_s = GAP;
        end else begin
          next_state_s = GRANT;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, grant, hold counter and sample registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      sel        <= 3'd0;
      gnt        <= 8'h00;
      busy       <= 1'b0;
      data_o     <= 1'b0;
      data_valid <= 1'b0;
      cnt_r      <= '0;
      ptr_r      <= 3'd7;
    end else begin
      state_r    <= next_state_s;
      busy       <= (next_state_s != IDLE);
      data_valid <= (state_r == GRANT);
      if (state_r == GRANT) begin
        data_o <= mux_o;
      end else begin
        data_o <= data_o;
      end
      if (take_s) begin
        sel   <= winner_s;
        gnt   <= 8'h01 << winner_s;
        ptr_r <= winner_s;
        cnt_r <= CNT_ONE;
      end else if (next_state_s == GRANT) begin
        // Staying granted: count saturates so a lone requester never expires.
        if (cnt_r != HOLD_LIM) begin
          cnt_r <= cnt_r + CNT_ONE;
        end else begin
          cnt_r <= cnt_r;
        end
      end else begin
        gnt <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Self-checking bench for mux8_rr_scheduler: vector table, directed corner
// sequences, and randomized traffic against a behavioural model.
module tb_mux8_rr_scheduler;

  localparam int HOLD4 = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] mux_i;
  logic       mux_o;
  logic       mux_o1;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       data_o;
  logic       data_valid;
  logic [2:0] sel1;
  logic [7:0] gnt1;
  logic       busy1;
  logic       data_o1;
  logic       data_valid1;

  int checks   = 0;
  int failures = 0;

  assign mux_o  = mux_i[sel];
  assign mux_o1 = mux_i[sel1];

  mux8_rr_scheduler #(.HOLD_MAX(HOLD4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mux_o(mux_o),
    .sel(sel), .gnt(gnt), .busy(busy), .data_o(data_o), .data_valid(data_valid)
  );

  mux8_rr_scheduler #(.HOLD_MAX(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mux_o(mux_o1),
    .sel(sel1), .gnt(gnt1), .busy(busy1), .data_o(data_o1), .data_valid(data_valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       valid;
  } vec_t;

  vec_t vt[12];

  // Behavioural model: phase 0=idle, 1=granted, 2=guard gap.
  int   m_phase;
  int   m_owner;
  int   m_ptr;
  int   m_held;
  logic m_data;
  logic m_valid;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    mux_i = 8'h00;
    tick();
    rst_n = 1'b1;
    m_phase = 0; m_owner = 0; m_ptr = 7; m_held = 0; m_data = 1'b0; m_valid = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] mask;
    bit         leave;
    bit         found;
    int         idx;
    m_valid = (m_phase == 1);
    if (m_phase == 1) m_data = mux_i[m_owner];
    if (m_phase == 1) begin
      mask  = 8'h01 << m_owner;
      leave = !req[m_owner] || !en || (m_held >= HOLD4 && (req & ~mask) != 8'h00);
      if (leave) m_phase = 2;
      else if (m_held < HOLD4) m_held++;
    end else if (en && req != 8'h00) begin
      found = 0;
      for (int k = 1; k <= 8; k++) begin
        idx = (m_ptr + k) % 8;
        if (!found && req[idx]) begin
          found = 1;
          m_owner = idx;
        end
      end
      m_ptr = m_owner; m_held = 1; m_phase = 1;
    end else begin
      m_phase = 0;
    end
  endtask

  initial begin
    logic [7:0] exp5;
    int         n;
    logic [7:0] onehot;

    vt[0]  = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
    vt[2]  = '{1'b1, 8'h18, 8'h00, 3'd0, 1'b1, 1'b1};
    vt[3]  = '{1'b1, 8'h18, 8'h08, 3'd3, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 8'h18, 8'h08, 3'd3, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 8'h18, 8'h08, 3'd3, 1'b1, 1'b1};
    vt[6]  = '{1'b1, 8'h10, 8'h00, 3'd3, 1'b1, 1'b1};
    vt[7]  = '{1'b1, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 8'h10, 8'h00, 3'd4, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 8'h10, 8'h00, 3'd4, 1'b0, 1'b0};
    vt[10] = '{1'b0, 8'h10, 8'h00, 3'd4, 1'b0, 1'b0};
    vt[11] = '{1'b1, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0};

    rst_n = 1'b0; en = 1'b0; req = 8'h00; mux_i = 8'h00;
    #2;
    check("rst_gnt", gnt, 8'h00);
    check("rst_sel", 8'(sel), 8'h00);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_valid", 8'(data_valid), 8'h00);
    check("rst_data", 8'(data_o), 8'h00);

    // Vector table: first grant, req drop mid-grant, en drop.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      en  = vt[i].en;
      req = vt[i].req;
      tick();
      check($sformatf("vec%0d_gnt", i), gnt, vt[i].gnt);
      check($sformatf("vec%0d_sel", i), 8'(sel), 8'(vt[i].sel));
      check($sformatf("vec%0d_busy", i), 8'(busy), 8'(vt[i].busy));
      check($sformatf("vec%0d_valid", i), 8'(data_valid), 8'(vt[i].valid));
    end

    // All requesting: 4 grant cycles then one gap, inputs in order.
    do_reset();
    en = 1'b1; req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      onehot = 8'h01 << (k % 8);
      for (int c = 0; c < HOLD4; c++) begin
        tick();
        check($sformatf("rr%0d_gnt", k), gnt, onehot);
      end
      tick();
      check($sformatf("rr%0d_gap", k), gnt, 8'h00);
    end

    // Lone requester keeps the grant with no gap.
    do_reset();
    en = 1'b1; req = 8'h20;
    tick();
    check("lone_first", gnt, 8'h20);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("lone_gnt", gnt, 8'h20);
      check("lone_sel", 8'(sel), 8'h05);
      check("lone_valid", 8'(data_valid), 8'h01);
    end

    // Mux sampling with HOLD_MAX=1 instance.
    do_reset();
    exp5 = 8'hA5;
    mux_i = 8'hA5; en = 1'b1; req = 8'hFF;
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      tick();
      if (data_valid1) begin
        check($sformatf("sample%0d", n), 8'(data_o1), 8'(exp5[n]));
        n++;
      end
    end
    check("sample_count", 8'(n), 8'd8);

    // Async reset mid-grant, then ptr restarts at 7.
    do_reset();
    en = 1'b1; req = 8'h40;
    tick();
    check("pre_rst_gnt", gnt, 8'h40);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", gnt, 8'h00);
    check("async_sel", 8'(sel), 8'h00);
    check("async_busy", 8'(busy), 8'h00);
    check("async_valid", 8'(data_valid), 8'h00);
    req = 8'h81;
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_gnt", gnt, 8'h01);
    check("post_rst_sel", 8'(sel), 8'h00);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      en    = ($urandom_range(0, 15) != 0);
      mux_i = 8'($urandom);
      @(posedge clk);
      model_step();
      #1;
      onehot = (m_phase == 1) ? (8'h01 << m_owner) : 8'h00;
      check("rnd_gnt", gnt, onehot);
      check("rnd_sel", 8'(sel), 8'(m_owner));
      check("rnd_busy", 8'(busy), 8'(m_phase != 0));
      check("rnd_valid", 8'(data_valid), 8'(m_valid));
      check("rnd_data", 8'(data_o), 8'(m_data));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux8_rr_scheduler.md
Name: mux8_rr_scheduler

Overview:
Round-robin scheduler that shares one 8:1 single-bit mux between eight requesters. It arbitrates the request lines, drives the mux select, and bounds each grant with a hold limit. It captures the mux output into a registered sample stream with a valid flag. It sits directly in front of the existing 8:1 mux: sel drives the mux select, and the mux output returns on mux_o.

Parameters:
HOLD_MAX, 16, maximum cycles per grant while other requests are pending; legal range 1..255.
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  scheduler enable; when low, no new grants are issued
req  input  8  level request per mux input; bit k requests mux input k
mux_o  input  1  output of the 8:1 mux (i[sel])
sel  output  3  mux select, registered
gnt  output  8  one-hot grant, registered; 0 when nothing is granted
busy  output  1  high when state != IDLE, registered
data_o  output  1  registered sample of mux_o
data_valid  output  1  high when data_o holds a sample taken during a grant

Behaviour:
- Reset (rst_n low, async): state=IDLE, sel=0, gnt=0, busy=0, data_o=0, data_valid=0, cnt=0, ptr=7. With ptr=7, input 0 has highest priority on the first arbitration.
- States: IDLE, GRANT, GAP.
- Arbitration (evaluated in IDLE and GAP): if en && |req, the winner is the first set bit of req scanning ptr+1, ptr+2, ... mod 8.
  - Next edge: state=GRANT, sel=winner, gnt=1<<winner, ptr=winner, cnt=1.
  - Otherwise: state=IDLE.
- Latency: req sampled high at edge N gives gnt/sel valid after edge N (one-cycle latency from IDLE).
- GRANT, each cycle:
  - Leave if any of: req[sel]==0; en==0; cnt==HOLD_MAX and (req & ~gnt)!=0. On leave, next state=GAP and gnt=0.
  - Otherwise stay: cnt increments, saturating at HOLD_MAX.
  - A lone requester keeps the grant indefinitely, with no gap, and sel stays constant.
  - Simultaneous exit causes (e.g. req drop plus hold expiry) produce exactly one GAP cycle.
- GAP: exactly one cycle with gnt=0, which gives a mux switching guard. Arbitration then proceeds as in IDLE, so the next grant appears at the edge ending GAP.
- sel holds its last value in GAP and IDLE and changes only when entering GRANT.
- Data capture, every edge:
  - data_o <= mux_o if state==GRANT, else data_o holds its value.
  - data_valid <= (state==GRANT).
  - data_valid therefore lags gnt by one cycle and covers exactly one sample per GRANT cycle.
- busy <= (next_state != IDLE), so busy aligns with gnt on grant start and stays high through GAP.
- Requests appearing or vanishing for non-granted inputs during GRANT affect only the hold-expiry check.
- en low in IDLE/GAP: no grant issued; state goes to or stays IDLE.
- Reset asserted mid-grant clears every output immediately, without a clock edge. After release, the first grant follows the ptr=7 rule.

Test Plan:
1. Reset, en=1, req=8'h01 -> one edge later gnt=8'h01, sel=0, busy=1. One further edge later data_valid=1.
2. HOLD_MAX=4, req=8'hFF held -> grants 0,1,2,...,7,0 in order. Each grant is gnt-high for 4 cycles followed by 1 GAP cycle with gnt=0; the period is 5 cycles per input.
3. HOLD_MAX=4, only req=8'h20 held for 20 cycles -> gnt=8'h20 and sel=5 continuously, no GAP, data_valid high continuously from the second cycle.
4. req=8'h18, input 3 granted, req[3] dropped after 2 grant cycles -> gnt=0 for one cycle, then gnt=8'h10, sel=4.
5. Mux model i=8'hA5 with mux_o=i[sel], HOLD_MAX=1, req=8'hFF -> the data_o samples taken while data_valid=1 read 1,0,1,0,0,1,0,1 for inputs 0..7.
6. Assert rst_n=0 mid-grant (gnt=8'h40) between clock edges -> gnt, sel, busy, data_valid are 0 immediately. Release with req=8'h81 -> first grant goes to input 0.
